// File: rtl/m_stbuf_pkg.sv
// Shared definitions for the posted-write store buffer: entry field widths
// and the full-word byte-enable constant. Entry layout is {valid, addr[AW-1:2], be, data}.
package m_stbuf_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int OFFS_W = 2;

  localparam logic [BE_W-1:0] BE_FULL = 4'hf;

  // Width of one packed entry for a given byte-address width
  function automatic int entry_w(input int aw);
    return 1 + (aw - OFFS_W) + BE_W + DATA_W;
  endfunction

endpackage

// File: rtl/m_store_buffer_if.sv
// Processor/memory-side signal bundle of the store buffer. The buffer uses the
// slave modport; the processor and data-memory environment uses master.
interface m_store_buffer_if
  import m_stbuf_pkg::*;
#(
  parameter int AW = 32
);

  logic              w_st_valid;
  logic              w_st_ready;
  logic [AW-1:0]     w_st_addr;
  logic [DATA_W-1:0] w_st_data;
  logic [BE_W-1:0]   w_st_be;

  logic              w_ld_valid;
  logic [AW-1:0]     w_ld_addr;
  logic              w_ld_hit;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_stall;

  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [BE_W-1:0]   w_mem_be;
  logic              w_mem_ready;

  logic              w_empty;

  modport master (
    output w_st_valid, w_st_addr, w_st_data, w_st_be,
    output w_ld_valid, w_ld_addr,
    output w_mem_ready,
    input  w_st_ready, w_ld_hit, w_ld_data, w_ld_stall,
    input  w_mem_we, w_mem_addr, w_mem_wdata, w_mem_be,
    input  w_empty
  );

  modport slave (
    input  w_st_valid, w_st_addr, w_st_data, w_st_be,
    input  w_ld_valid, w_ld_addr,
    input  w_mem_ready,
    output w_st_ready, w_ld_hit, w_ld_data, w_ld_stall,
    output w_mem_we, w_mem_addr, w_mem_wdata, w_mem_be,
    output w_empty
  );

endinterface

// File: rtl/m_stbuf_match.sv
// Youngest-match priority search over the live store entries (head .. head+count-1).
// A later (younger) matching entry overrides any older one.
module m_stbuf_match
  import m_stbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1,
  localparam int WAW  = AW - OFFS_W
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [WAW-1:0]   waddr_i [DEPTH],
  input  logic [BE_W-1:0]  be_i    [DEPTH],
  input  logic [PW-1:0]    head_i,
  input  logic [CW-1:0]    count_i,
  input  logic [WAW-1:0]   key_i,
  output logic             match_o,
  output logic [PW-1:0]    idx_o,
  output logic             full_o
);

  logic [PW-1:0] pos_s;
  logic          hit_s;

  // Walk oldest to youngest so the last hit is the youngest matching entry
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    full_o  = 1'b0;
    pos_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pos_s   = head_i + PW'(k);
      hit_s   = (CW'(k) < count_i) && valid_i[pos_s] && (waddr_i[pos_s] == key_i);
      match_o = match_o | hit_s;
      idx_o   = hit_s ? pos_s : idx_o;
      full_o  = hit_s ? (be_i[pos_s] == BE_FULL) : full_o;
    end
  end

endmodule

// File: rtl/m_store_buffer.sv
// Posted-write store buffer: FIFO of word stores drained one per cycle to data
// memory, with load lookup. Full-word forwarding is built only when STBUF_FWD_EN is defined.
module m_store_buffer
  import m_stbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  m_store_buffer_if.slave bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - OFFS_W;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WAW-1:0]    waddr_q [DEPTH];
  logic [WAW-1:0]    waddr_d [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [BE_W-1:0]   be_d    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic          st_ready_s;
  logic          mem_we_s;
  logic          push_s;
  logic          pop_s;
  logic          m_match_s;
  logic [PW-1:0] m_idx_s;
  logic          m_full_s;
  logic          unused_s;

  // Full only when every slot is occupied; a same-cycle pop does not open a slot
  assign st_ready_s = (count_q != CW'(DEPTH));
  assign mem_we_s   = (count_q != {CW{1'b0}});
  assign push_s     = bus.w_st_valid && st_ready_s;
  assign pop_s      = mem_we_s && bus.w_mem_ready;

  // Next-state for pointers, occupancy and entry storage
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    data_d  = data_q;

    if (push_s) begin
      waddr_d[tail_q] = bus.w_st_addr[AW-1:OFFS_W];
      be_d[tail_q]    = bus.w_st_be;
      data_d[tail_q]  = bus.w_st_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending entry
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        be_q[i]    <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign bus.w_st_ready  = st_ready_s;
  assign bus.w_mem_we    = mem_we_s;
  assign bus.w_mem_addr  = {waddr_q[head_q], {OFFS_W{1'b0}}};
  assign bus.w_mem_wdata = data_q[head_q];
  assign bus.w_mem_be    = be_q[head_q];
  assign bus.w_empty     = (count_q == {CW{1'b0}});

  m_stbuf_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .valid_i (valid_q),
    .waddr_i (waddr_q),
    .be_i    (be_q),
    .head_i  (head_q),
    .count_i (count_q),
    .key_i   (bus.w_ld_addr[AW-1:OFFS_W]),
    .match_o (m_match_s),
    .idx_o   (m_idx_s),
    .full_o  (m_full_s)
  );

`ifdef STBUF_FWD_EN
  // A partial youngest match cannot be merged with memory data, so it stalls
  assign bus.w_ld_hit   = bus.w_ld_valid && m_match_s && m_full_s;
  assign bus.w_ld_stall = bus.w_ld_valid && m_match_s && !m_full_s;
  assign bus.w_ld_data  = (bus.w_ld_valid && m_match_s && m_full_s) ? data_q[m_idx_s] : {DATA_W{1'b0}};
  assign unused_s       = ^{bus.w_st_addr[OFFS_W-1:0], bus.w_ld_addr[OFFS_W-1:0]};
`else
  assign bus.w_ld_hit   = 1'b0;
  assign bus.w_ld_stall = bus.w_ld_valid && m_match_s;
  assign bus.w_ld_data  = {DATA_W{1'b0}};
  assign unused_s       = ^{bus.w_st_addr[OFFS_W-1:0], bus.w_ld_addr[OFFS_W-1:0], m_idx_s, m_full_s};
`endif

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer (DEPTH=4, AW=32); load expectations follow STBUF_FWD_EN.
module tb_m_store_buffer;
  import m_stbuf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  m_store_buffer_if #(.AW(32)) bus ();

  m_store_buffer #(.DEPTH(4), .AW(32)) dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.w_st_valid = 1'b1;
    bus.w_st_addr  = addr;
    bus.w_st_data  = data;
    bus.w_st_be    = be;
    tick();
    bus.w_st_valid = 1'b0;
  endtask

  task automatic drain_one();
    bus.w_mem_ready = 1'b1;
    tick();
    bus.w_mem_ready = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic exp_hit,
                          input logic [31:0] exp_data, input logic exp_stall);
    bus.w_ld_valid = 1'b1;
    bus.w_ld_addr  = addr;
    #1;
    check({tag, "_hit"}, 64'(bus.w_ld_hit), 64'(exp_hit));
    check({tag, "_data"}, 64'(bus.w_ld_data), 64'(exp_data));
    check({tag, "_stall"}, 64'(bus.w_ld_stall), 64'(exp_stall));
    bus.w_ld_valid = 1'b0;
  endtask

  // Full-word youngest match: forwarded with the feature, stalled without it
  task automatic load_full(input string tag, input logic [31:0] addr, input logic [31:0] data);
`ifdef STBUF_FWD_EN
    load_chk(tag, addr, 1'b1, data, 1'b0);
`else
    load_chk(tag, addr, 1'b0, 32'h0, 1'b1);
`endif
  endtask

  initial begin
    bus.w_st_valid  = 1'b0;
    bus.w_st_addr   = 32'h0;
    bus.w_st_data   = 32'h0;
    bus.w_st_be     = 4'h0;
    bus.w_ld_valid  = 1'b0;
    bus.w_ld_addr   = 32'h0;
    bus.w_mem_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_st_ready", 64'(bus.w_st_ready), 64'h1);
    check("rst_mem_we", 64'(bus.w_mem_we), 64'h0);
    check("rst_empty", 64'(bus.w_empty), 64'h1);
    check("rst_mem_addr", 64'(bus.w_mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(bus.w_mem_wdata), 64'h0);
    check("rst_mem_be", 64'(bus.w_mem_be), 64'h0);
    load_chk("rst_ld", 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Fill to DEPTH with memory stalled; a 5th store is refused even with a same-cycle pop
    push(32'h10, 32'hA0, 4'hf);
    check("fill1_mem_we", 64'(bus.w_mem_we), 64'h1);
    check("fill1_empty", 64'(bus.w_empty), 64'h0);
    push(32'h14, 32'hA1, 4'hf);
    push(32'h18, 32'hA2, 4'hf);
    check("fill3_st_ready", 64'(bus.w_st_ready), 64'h1);
    push(32'h1C, 32'hA3, 4'hf);
    check("full_st_ready", 64'(bus.w_st_ready), 64'h0);
    check("full_mem_addr", 64'(bus.w_mem_addr), 64'h10);
    check("full_mem_wdata", 64'(bus.w_mem_wdata), 64'hA0);
    check("full_mem_be", 64'(bus.w_mem_be), 64'hF);
    bus.w_st_valid = 1'b1;
    bus.w_st_addr  = 32'h20;
    bus.w_st_data  = 32'hEE;
    bus.w_st_be    = 4'hf;
    tick();
    check("refuse_st_ready", 64'(bus.w_st_ready), 64'h0);
    check("refuse_wdata", 64'(bus.w_mem_wdata), 64'hA0);
    bus.w_mem_ready = 1'b1;
    #1;
    check("full_pop_st_ready", 64'(bus.w_st_ready), 64'h0);
    tick();
    bus.w_st_valid = 1'b0;
    check("drain_a1", 64'(bus.w_mem_wdata), 64'hA1);
    check("drain_a1_addr", 64'(bus.w_mem_addr), 64'h14);
    tick();
    check("drain_a2", 64'(bus.w_mem_wdata), 64'hA2);
    tick();
    check("drain_a3", 64'(bus.w_mem_wdata), 64'hA3);
    check("drain_a3_we", 64'(bus.w_mem_we), 64'h1);
    tick();
    check("drained_empty", 64'(bus.w_empty), 64'h1);
    check("drained_mem_we", 64'(bus.w_mem_we), 64'h0);
    bus.w_mem_ready = 1'b0;

    // Forwarding of a full word, byte offset ignored, other words and idle lookup
    push(32'h8, 32'h7, 4'hf);
    load_full("fwd7", 32'h8, 32'h7);
    load_full("fwd7_off", 32'hB, 32'h7);
    load_chk("miss_c", 32'hC, 1'b0, 32'h0, 1'b0);
    bus.w_ld_addr = 32'h8;
    #1;
    check("ldv0_hit", 64'(bus.w_ld_hit), 64'h0);
    check("ldv0_stall", 64'(bus.w_ld_stall), 64'h0);

    // Youngest match wins; drain order stays 7 then 9; popping entry still visible
    push(32'h8, 32'h9, 4'hf);
    load_full("young9", 32'h8, 32'h9);
    check("ord_first", 64'(bus.w_mem_wdata), 64'h7);
    bus.w_mem_ready = 1'b1;
    tick();
    check("ord_second", 64'(bus.w_mem_wdata), 64'h9);
    check("ord_second_addr", 64'(bus.w_mem_addr), 64'h8);
    load_full("popping9", 32'h8, 32'h9);
    tick();
    check("ord_empty", 64'(bus.w_empty), 64'h1);
    bus.w_mem_ready = 1'b0;
    load_chk("after_drain", 32'h8, 1'b0, 32'h0, 1'b0);

    // Partial store stalls until it drains
    push(32'h9, 32'h0000AB00, 4'b0010);
    load_chk("sb_stall", 32'h8, 1'b0, 32'h0, 1'b1);
    check("sb_mem_addr", 64'(bus.w_mem_addr), 64'h8);
    check("sb_mem_be", 64'(bus.w_mem_be), 64'h2);
    drain_one();
    load_chk("sb_popped", 32'h8, 1'b0, 32'h0, 1'b0);

    // Partial then full word: youngest full wins; full then partial: stall
    push(32'h9, 32'h0000AB00, 4'b0010);
    push(32'h8, 32'h33, 4'hf);
    load_full("sb_sw", 32'h8, 32'h33);
    push(32'hA, 32'h00CD0000, 4'b0100);
    load_chk("sw_sb", 32'h8, 1'b0, 32'h0, 1'b1);
    drain_one();
    drain_one();
    drain_one();
    check("mix_empty", 64'(bus.w_empty), 64'h1);

    // Back-to-back pushes with memory always ready; pointers wrap past DEPTH-1
    bus.w_mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.w_st_valid = 1'b1;
      bus.w_st_addr  = 32'h100 + 32'(i) * 32'h4;
      bus.w_st_data  = 32'h1000 + 32'(i);
      bus.w_st_be    = 4'hf;
      tick();
      check($sformatf("stream%0d_wdata", i), 64'(bus.w_mem_wdata), 64'h1000 + 64'(i));
      check($sformatf("stream%0d_ready", i), 64'(bus.w_st_ready), 64'h1);
    end
    bus.w_st_valid = 1'b0;
    tick();
    check("stream_empty", 64'(bus.w_empty), 64'h1);
    bus.w_mem_ready = 1'b0;

    // Reset with three entries pending discards them
    push(32'h200, 32'h51, 4'hf);
    push(32'h204, 32'h52, 4'hf);
    push(32'h208, 32'h53, 4'hf);
    check("pend_mem_we", 64'(bus.w_mem_we), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_we", 64'(bus.w_mem_we), 64'h0);
    check("midrst_empty", 64'(bus.w_empty), 64'h1);
    check("midrst_st_ready", 64'(bus.w_st_ready), 64'h1);
    check("midrst_mem_addr", 64'(bus.w_mem_addr), 64'h0);
    tick();
    rst_n = 1'b1;
    bus.w_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_we", i), 64'(bus.w_mem_we), 64'h0);
    end
    load_chk("post_rst_ld", 32'h200, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
